// File: rtl/smc_sysid_checker.sv
// -----------------------------------------------------------------------------
// smc_sysid_checker
//
// Boot-time Avalon-MM read master. Reads the system-ID word (address 0) and the
// build-timestamp word (address 1) from the system-ID slave, compares them
// against the expected build constants and gates the stepper-motor-control
// enable. A mismatch or a stalled bus leaves the motor controller disabled and
// raises a flag that holds until the next check is started.
//
// Build option:
//   SMC_SYSID_TS_CHECK_EN  defined   -> PASS needs both ID and timestamp match.
//                          undefined -> timestamp is captured for software
//                                       visibility only; the ID alone decides.
//
// Ports:
//   clock           in   system clock
//   reset           in   asynchronous, active-high reset
//   start           in   single-cycle request to (re)run the check
//   av_address      out  word address to the system-ID slave (registered)
//   av_read         out  read strobe (registered)
//   av_waitrequest  in   slave stall
//   av_readdata     in   [31:0] slave read data
//   id_value        out  [31:0] captured ID word
//   ts_value        out  [31:0] captured timestamp word
//   busy            out  check in progress
//   done            out  check finished (pass or fail), held until next run
//   id_ok           out  the ID matched (valid while done=1)
//   timeout         out  a read stalled for TIMEOUT_CYCLES
//   smc_enable      out  high only when the check passed
// -----------------------------------------------------------------------------
module smc_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd67108864,
    parameter logic [31:0] EXPECTED_TS    = 32'd1413881659,
    parameter int          READ_LATENCY   = 1,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        av_address,
    output logic        av_read,
    input  logic        av_waitrequest,
    input  logic [31:0] av_readdata,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        timeout,
    output logic        smc_enable
);

    // Terminal counts, pre-sized to the counter widths so the compares are
    // width-exact. The latency counter starts at 0 on the acceptance edge, so
    // data is captured when it holds READ_LATENCY-1.
    localparam logic [2:0]  LAT_LAST = 3'(READ_LATENCY - 1);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        WT_ID,
        RD_TS,
        WT_TS,
        CHECK,
        PASS,
        FAIL
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [2:0]  lat_cnt;
    logic [15:0] to_cnt;
    logic        auto_pend;

    // Next-cycle values and one-cycle actions decoded from the current state.
    logic        rd_d;
    logic        addr_d;
    logic        run_start;
    logic        cap_id;
    logic        cap_ts;
    logic        do_check;
    logic        set_timeout;

    logic        accept;
    logic        stall;
    logic        to_expire;
    logic        lat_last;
    logic        id_match;
    logic        pass_cond;

    assign accept    = av_read && !av_waitrequest;
    assign stall     = av_read && av_waitrequest;
    assign to_expire = stall && (to_cnt == TO_LAST);
    assign lat_last  = (lat_cnt == LAT_LAST);
    assign id_match  = (id_value == EXPECTED_ID);

`ifdef SMC_SYSID_TS_CHECK_EN
    logic ts_match;
    assign ts_match  = (ts_value == EXPECTED_TS);
    assign pass_cond = id_match && ts_match;
`else
    assign pass_cond = id_match;
`endif

    // -------------------------------------------------------------------------
    // Next-state and action decode
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        rd_d        = 1'b0;
        addr_d      = av_address;
        run_start   = 1'b0;
        cap_id      = 1'b0;
        cap_ts      = 1'b0;
        do_check    = 1'b0;
        set_timeout = 1'b0;

        case (state_q)
            IDLE: begin
                // auto_pend is only set on the first edge after reset release.
                if (start || auto_pend) begin
                    state_d   = RD_ID;
                    rd_d      = 1'b1;
                    addr_d    = 1'b0;
                    run_start = 1'b1;
                end
            end

            RD_ID: begin
                if (to_expire) begin
                    state_d     = FAIL;
                    set_timeout = 1'b1;
                end else if (accept) begin
                    state_d = WT_ID;
                end else begin
                    rd_d = 1'b1;
                end
            end

            WT_ID: begin
                if (lat_last) begin
                    cap_id  = 1'b1;
                    state_d = RD_TS;
                    rd_d    = 1'b1;
                    addr_d  = 1'b1;
                end
            end

            RD_TS: begin
                if (to_expire) begin
                    state_d     = FAIL;
                    set_timeout = 1'b1;
                end else if (accept) begin
                    state_d = WT_TS;
                end else begin
                    rd_d = 1'b1;
                end
            end

            WT_TS: begin
                if (lat_last) begin
                    cap_ts  = 1'b1;
                    state_d = CHECK;
                end
            end

            CHECK: begin
                do_check = 1'b1;
                state_d  = pass_cond ? PASS : FAIL;
            end

            PASS, FAIL: begin
                if (start) begin
                    state_d   = RD_ID;
                    rd_d      = 1'b1;
                    addr_d    = 1'b0;
                    run_start = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State, bus strobes and result registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            av_read    <= 1'b0;
            av_address <= 1'b0;
            auto_pend  <= AUTO_START;
            id_value   <= '0;
            ts_value   <= '0;
            id_ok      <= 1'b0;
            timeout    <= 1'b0;
            done       <= 1'b0;
            smc_enable <= 1'b0;
        end else begin
            state_q    <= state_d;
            av_read    <= rd_d;
            av_address <= addr_d;
            auto_pend  <= 1'b0;

            if (cap_id) begin
                id_value <= av_readdata;
            end
            if (cap_ts) begin
                ts_value <= av_readdata;
            end

            if (run_start) begin
                id_ok   <= 1'b0;
                timeout <= 1'b0;
            end else begin
                if (do_check) begin
                    id_ok <= id_match;
                end
                if (set_timeout) begin
                    timeout <= 1'b1;
                end
            end

            // done and smc_enable share one register stage so they always
            // move on the same edge; a restart drops both immediately.
            done       <= ((state_q == PASS) || (state_q == FAIL)) && !run_start;
            smc_enable <= (state_q == PASS) && !run_start;
        end
    end

    // -------------------------------------------------------------------------
    // Read-latency and stall counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lat_cnt <= '0;
        end else if ((state_q == WT_ID) || (state_q == WT_TS)) begin
            lat_cnt <= lat_cnt + 3'd1;
        end else begin
            lat_cnt <= '0;
        end
    end

    // Counts stall cycles of the read in flight; cleared whenever no read is
    // outstanding so each read gets its own budget.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (!av_read) begin
            to_cnt <= '0;
        end else if (av_waitrequest) begin
            to_cnt <= to_cnt + 16'd1;
        end
    end

    assign busy = (state_q != IDLE) && (state_q != PASS) && (state_q != FAIL);

endmodule

// File: tb/tb_smc_sysid_checker.sv
module tb_smc_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'd67108864;
    localparam logic [31:0] EXP_TS = 32'd1413881659;
    localparam int          LAT    = 1;
    localparam int          TMO    = 10;
`ifdef SMC_SYSID_TS_CHECK_EN
    localparam bit          TS_CHK = 1'b1;
`else
    localparam bit          TS_CHK = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        av_address;
    logic        av_read;
    logic        av_waitrequest;
    logic [31:0] av_readdata;
    logic [31:0] id_value;
    logic [31:0] ts_value;
    logic        busy;
    logic        done;
    logic        id_ok;
    logic        timeout;
    logic        smc_enable;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    smc_sysid_checker #(
        .EXPECTED_ID   (EXP_ID),
        .EXPECTED_TS   (EXP_TS),
        .READ_LATENCY  (LAT),
        .TIMEOUT_CYCLES(TMO),
        .AUTO_START    (1'b1)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .av_address    (av_address),
        .av_read       (av_read),
        .av_waitrequest(av_waitrequest),
        .av_readdata   (av_readdata),
        .id_value      (id_value),
        .ts_value      (ts_value),
        .busy          (busy),
        .done          (done),
        .id_ok         (id_ok),
        .timeout       (timeout),
        .smc_enable    (smc_enable)
    );

    // Behavioural system-ID slave: stalls the first wait_* cycles of each
    // read (or forever), then returns the word for the accepted address.
    logic [31:0] slv_id = EXP_ID;
    logic [31:0] slv_ts = EXP_TS;
    int          wait_id = 0;
    int          wait_ts = 0;
    bit          stall_forever = 1'b0;
    int          wcnt = 0;
    logic        rd_addr_q = 1'b0;

    assign av_waitrequest = av_read && (stall_forever || (wcnt < (av_address ? wait_ts : wait_id)));
    assign av_readdata    = rd_addr_q ? slv_ts : slv_id;

    always @(posedge clock) begin
        if (!av_read) wcnt <= 0;
        else if (av_waitrequest) wcnt <= wcnt + 1;
        if (av_read && !av_waitrequest) rd_addr_q <= av_address;
    end

    // Reference model
    function automatic bit model_pass(input logic [31:0] i, input logic [31:0] t);
        model_pass = (i == EXP_ID) && (!TS_CHK || (t == EXP_TS));
    endfunction

    // Each read costs an issue cycle, its stalls and the read latency; then
    // one compare cycle and one cycle for the registered result.
    function automatic int model_done_edge(input int wi, input int wt);
        model_done_edge = (1 + wi + LAT) + (1 + wt + LAT) + 2;
    endfunction

    // Stimulus only: starts a run and reports what was observed.
    task automatic run_once(input logic [31:0] idv, input logic [31:0] tsv,
                            input int wi, input int wt, input bit mid_start,
                            output int edges, output logic [5:0] snap0);
        @(negedge clock);
        slv_id = idv; slv_ts = tsv; wait_id = wi; wait_ts = wt;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        snap0 = {av_read, av_address, busy, done, id_ok, timeout};
        edges = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clock); #1;
            start = 1'b0;
            if (mid_start && k == 1) start = 1'b1;
            if (done) begin
                edges = k;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        int edges;
        reset = 1'b1; start = 1'b0;
        slv_id = EXP_ID; slv_ts = EXP_TS; wait_id = 0; wait_ts = 0;
        repeat (3) @(posedge clock);
        #1;
        n_cmp++;
        if ({av_read, av_address, busy, done, id_ok, timeout, smc_enable} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b expected 0000000", {av_read, av_address, busy, done, id_ok, timeout, smc_enable});
        end
        n_cmp++;
        if ({id_value, ts_value} !== 64'd0) begin
            n_err++;
            $display("FAIL reset_data: got %h %h expected 0", id_value, ts_value);
        end
        @(negedge clock); reset = 1'b0;
        edges = -1;
        for (int k = 0; k <= 200; k++) begin
            @(posedge clock); #1;
            if (done) begin edges = k; break; end
        end
        n_cmp++;
        if (edges !== model_done_edge(0, 0)) begin
            n_err++;
            $display("FAIL auto_start_edge: got %0d expected %0d", edges, model_done_edge(0, 0));
        end
        n_cmp++;
        if ({smc_enable, id_ok, id_value} !== {1'b1, 1'b1, EXP_ID}) begin
            n_err++;
            $display("FAIL auto_start_result: got en=%b ok=%b id=%0d expected en=1 ok=1 id=%0d", smc_enable, id_ok, id_value, EXP_ID);
        end
    endtask

    task automatic test_basic_pass();
        int edges; logic [5:0] s0;
        run_once(EXP_ID, EXP_TS, 0, 0, 1'b0, edges, s0);
        n_cmp++;
        if (s0[5:3] !== 3'b101) begin
            n_err++;
            $display("FAIL first_read: got rd/addr/busy=%b expected 101", s0[5:3]);
        end
        n_cmp++;
        if (edges !== 6) begin
            n_err++;
            $display("FAIL pass_done_edge: got %0d expected 6", edges);
        end
        n_cmp++;
        if ({smc_enable, id_ok, timeout, busy} !== 4'b1100) begin
            n_err++;
            $display("FAIL pass_flags: got en/ok/to/busy=%b expected 1100", {smc_enable, id_ok, timeout, busy});
        end
        n_cmp++;
        if (ts_value !== EXP_TS) begin
            n_err++;
            $display("FAIL pass_ts_value: got %0d expected %0d", ts_value, EXP_TS);
        end
    endtask

    task automatic test_bad_id();
        int edges; logic [5:0] s0;
        run_once(EXP_ID + 32'd1, EXP_TS, 0, 0, 1'b0, edges, s0);
        n_cmp++;
        if (edges !== model_done_edge(0, 0)) begin
            n_err++;
            $display("FAIL bad_id_edge: got %0d expected %0d", edges, model_done_edge(0, 0));
        end
        n_cmp++;
        if ({smc_enable, id_ok, id_value} !== {1'b0, 1'b0, EXP_ID + 32'd1}) begin
            n_err++;
            $display("FAIL bad_id_result: got en=%b ok=%b id=%0d expected en=0 ok=0 id=%0d", smc_enable, id_ok, id_value, EXP_ID + 32'd1);
        end
    endtask

    task automatic test_ts_zero();
        int edges; logic [5:0] s0;
        logic exp_en;
        exp_en = model_pass(EXP_ID, 32'd0);
        run_once(EXP_ID, 32'd0, 0, 0, 1'b0, edges, s0);
        n_cmp++;
        if ({smc_enable, id_ok, ts_value} !== {exp_en, 1'b1, 32'd0}) begin
            n_err++;
            $display("FAIL ts_zero: got en=%b ok=%b ts=%0d expected en=%b ok=1 ts=0", smc_enable, id_ok, ts_value, exp_en);
        end
    endtask

    task automatic test_waitrequest();
        int edges; logic [5:0] s0;
        run_once(EXP_ID, EXP_TS, 3, 3, 1'b0, edges, s0);
        n_cmp++;
        if (edges !== 12) begin
            n_err++;
            $display("FAIL wait3_edge: got %0d expected 12", edges);
        end
        n_cmp++;
        if ({smc_enable, timeout} !== 2'b10) begin
            n_err++;
            $display("FAIL wait3_result: got en/to=%b expected 10", {smc_enable, timeout});
        end
    endtask

    task automatic test_timeout();
        bit held;
        @(negedge clock);
        slv_id = EXP_ID; slv_ts = EXP_TS; wait_id = 0; wait_ts = 0;
        stall_forever = 1'b1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        held = 1'b1;
        for (int k = 1; k < TMO; k++) begin
            @(posedge clock); #1;
            if (!(av_read === 1'b1 && timeout === 1'b0)) held = 1'b0;
        end
        n_cmp++;
        if (held !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_early: got read dropped before cycle %0d expected held", TMO);
        end
        @(posedge clock); #1;
        n_cmp++;
        if ({av_read, timeout} !== 2'b01) begin
            n_err++;
            $display("FAIL timeout_edge: got rd/to=%b expected 01", {av_read, timeout});
        end
        @(posedge clock); #1;
        n_cmp++;
        if ({done, smc_enable, busy} !== 3'b100) begin
            n_err++;
            $display("FAIL timeout_result: got done/en/busy=%b expected 100", {done, smc_enable, busy});
        end
        stall_forever = 1'b0;
    endtask

    task automatic test_rerun();
        int edges; logic [5:0] s0;
        logic [31:0] new_ts;
        // Restart after the timeout failure: flags clear on the start edge.
        run_once(EXP_ID, EXP_TS, 0, 0, 1'b0, edges, s0);
        n_cmp++;
        if ({s0[2], s0[0]} !== 2'b00) begin
            n_err++;
            $display("FAIL rerun_clear_to: got done/to=%b expected 00", {s0[2], s0[0]});
        end
        n_cmp++;
        if ({edges, smc_enable} !== {32'd6, 1'b1}) begin
            n_err++;
            $display("FAIL rerun_after_to: got edge=%0d en=%b expected edge=6 en=1", edges, smc_enable);
        end
        // Restart from a pass with a different timestamp.
        new_ts = $urandom();
        run_once(EXP_ID, new_ts, 0, 0, 1'b0, edges, s0);
        n_cmp++;
        if ({s0[2], s0[1]} !== 2'b00) begin
            n_err++;
            $display("FAIL rerun_clear_ok: got done/ok=%b expected 00", {s0[2], s0[1]});
        end
        n_cmp++;
        if ({ts_value, smc_enable} !== {new_ts, model_pass(EXP_ID, new_ts)}) begin
            n_err++;
            $display("FAIL rerun_recapture: got ts=%h en=%b expected ts=%h en=%b", ts_value, smc_enable, new_ts, model_pass(EXP_ID, new_ts));
        end
    endtask

    task automatic test_start_busy();
        int edges; logic [5:0] s0;
        run_once(EXP_ID, EXP_TS, 0, 0, 1'b1, edges, s0);
        n_cmp++;
        if ({edges, smc_enable} !== {32'd6, 1'b1}) begin
            n_err++;
            $display("FAIL start_busy: got edge=%0d en=%b expected edge=6 en=1", edges, smc_enable);
        end
        repeat (3) @(posedge clock);
        #1;
        n_cmp++;
        if ({done, smc_enable, busy, av_read} !== 4'b1100) begin
            n_err++;
            $display("FAIL pass_hold: got done/en/busy/rd=%b expected 1100", {done, smc_enable, busy, av_read});
        end
    endtask

    task automatic test_reset_mid();
        int edges;
        @(negedge clock);
        slv_id = EXP_ID; slv_ts = EXP_TS; wait_id = 0; wait_ts = 0;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({av_read, av_address, busy, done, id_ok, timeout, smc_enable, id_value, ts_value} !== 71'd0) begin
            n_err++;
            $display("FAIL reset_mid: got rd=%b busy=%b done=%b en=%b id=%h ts=%h expected all 0", av_read, busy, done, smc_enable, id_value, ts_value);
        end
        @(posedge clock);
        @(negedge clock); reset = 1'b0;
        edges = -1;
        for (int k = 0; k <= 200; k++) begin
            @(posedge clock); #1;
            if (done) begin edges = k; break; end
        end
        n_cmp++;
        if ({edges, smc_enable, id_ok} !== {32'd6, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL reset_mid_restart: got edge=%0d en=%b ok=%b expected edge=6 en=1 ok=1", edges, smc_enable, id_ok);
        end
    endtask

    task automatic test_random();
        int edges; logic [5:0] s0;
        logic [31:0] i, t;
        int wi, wt;
        for (int n = 0; n < 16; n++) begin
            i  = ($urandom_range(1, 0) == 1) ? EXP_ID : $urandom();
            t  = ($urandom_range(1, 0) == 1) ? EXP_TS : $urandom();
            wi = $urandom_range(4, 0);
            wt = $urandom_range(4, 0);
            run_once(i, t, wi, wt, 1'b0, edges, s0);
            n_cmp++;
            if (edges !== model_done_edge(wi, wt)) begin
                n_err++;
                $display("FAIL rand_edge[%0d]: got %0d expected %0d", n, edges, model_done_edge(wi, wt));
            end
            n_cmp++;
            if ({smc_enable, id_ok, timeout, id_value, ts_value} !== {model_pass(i, t), (i == EXP_ID), 1'b0, i, t}) begin
                n_err++;
                $display("FAIL rand_result[%0d]: got en=%b ok=%b to=%b id=%h ts=%h expected en=%b ok=%b to=0 id=%h ts=%h", n, smc_enable, id_ok, timeout, id_value, ts_value, model_pass(i, t), (i == EXP_ID), i, t);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        test_reset();
        test_basic_pass();
        test_bad_id();
        test_ts_zero();
        test_waitrequest();
        test_timeout();
        test_rerun();
        test_start_busy();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/smc_sysid_checker.md
# smc_sysid_checker

Boot-time Avalon-MM read master that fetches the system ID and build timestamp words from the system-ID slave, compares them with expected values, and gates the stepper-motor-control enable. Sits between the system-ID slave (which it reads) and the motor-control datapath (which it enables). A mismatch or a bus timeout holds the motor controller disabled and raises a sticky error flag.

## Interface
Parameters:
- EXPECTED_ID, 67108864: required word at address 0.
- EXPECTED_TS, 1413881659: required word at address 1.
- READ_LATENCY, 1: cycles from read acceptance to valid readdata; legal range 1..7.
- TIMEOUT_CYCLES, 255: maximum cycles a read may stall on waitrequest; range 1..65535.
- AUTO_START, 1: if 1, a check starts on the first clock edge after reset deasserts.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to (re)run the check.
- av_address  out  1  word address to the system-ID slave.
- av_read  out  1  read strobe.
- av_waitrequest  in  1  slave stall; tie to 0 for a zero-wait slave.
- av_readdata  in  32  slave read data.
- id_value  out  32  captured ID word.
- ts_value  out  32  captured timestamp word.
- busy  out  1  check in progress.
- done  out  1  check finished (PASS or FAIL); held until the next run.
- id_ok  out  1  the ID matched.
- timeout  out  1  a read exceeded TIMEOUT_CYCLES.
- smc_enable  out  1  high only in PASS.

## Operation
- States: IDLE, RD_ID, WT_ID, RD_TS, WT_TS, CHECK, PASS, FAIL.
- IDLE: accepts start, or the first edge after reset if AUTO_START=1, and moves to RD_ID.
- RD_ID: av_read=1, av_address=0. The read is accepted on the edge where av_read and !av_waitrequest are both true; the FSM then moves to WT_ID.
- WT_ID: latency counter counts to READ_LATENCY. av_readdata is captured into id_value on the edge the count reaches READ_LATENCY; the FSM then moves to RD_TS.
- RD_TS and WT_TS: same sequence with av_address=1, capturing into ts_value. The FSM then moves to CHECK.
- CHECK: one cycle. id_ok = (id_value == EXPECTED_ID). The FSM goes to PASS if the required comparisons hold, otherwise to FAIL.
- PASS and FAIL: done=1. A new start clears done, id_ok and timeout, then goes to RD_ID.
- start is ignored in all other states.
- Timeout: a 16-bit counter runs while av_read && av_waitrequest. When it reaches TIMEOUT_CYCLES, the FSM deasserts av_read, sets timeout=1 and goes to FAIL.
- av_read and av_address are registered. av_read is high only in RD_ID and RD_TS.
- busy=1 in every state except IDLE, PASS and FAIL.

## Timing
- Reset values: all outputs are 0, and the FSM is in IDLE.
- Reset asserted mid-operation immediately drops av_read, smc_enable and busy, and returns the FSM to IDLE. Nothing is retained.
- Zero-wait slave with READ_LATENCY=1:
  - start is sampled at edge 0.
  - av_read is high in cycle 1 (address 0).
  - id_value is captured at edge 2.
  - av_read is high in cycle 3 (address 1).
  - ts_value is captured at edge 4.
  - CHECK is evaluated at edge 5.
  - done and smc_enable rise at edge 6.
- Each waitrequest cycle adds one cycle. Each extra unit of READ_LATENCY adds one cycle per read.
- done and smc_enable change only on the same edge.
- id_ok is valid whenever done=1.

## Configuration
- SMC_SYSID_TS_CHECK_EN defined: PASS requires both the ID and the timestamp to match.
- SMC_SYSID_TS_CHECK_EN undefined: the timestamp is still read and captured into ts_value, but only the ID match decides PASS.

## Test plan
- Model slave returns 67108864 and 1413881659 with zero wait; start pulse -> done and smc_enable high at edge 6, id_ok=1, timeout=0.
- Slave returns ID 67108865 -> FAIL: done=1, smc_enable=0, id_ok=0.
- Correct ID, timestamp 0: with SMC_SYSID_TS_CHECK_EN -> FAIL, id_ok=1; without the macro -> PASS.
- waitrequest held high for 3 cycles on each read -> PASS, done at edge 12. waitrequest held high permanently with TIMEOUT_CYCLES=10 -> av_read drops, timeout=1 and FAIL 10 cycles after the read is issued.
- reset pulsed during WT_TS -> all outputs 0 the same cycle. With AUTO_START=1, a new sequence begins after release and PASSes.
- start pulsed while busy -> ignored. start in PASS -> done clears, rerun completes, and values are recaptured.
